// File: rtl/mfp_ahb_matrix_pkg.sv
// Shared AHB-lite encodings, default slave address map and state types for mfp_ahb_matrix.
package mfp_ahb_matrix_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Legacy map: slave0 boot ROM, slave1 program RAM, slave2 GPIO (slave i at [i*32+:32]).
  localparam logic [95:0] DEF_SLV_BASE = {32'h1F80_0000, 32'h0000_0000, 32'h1FC0_0000};
  localparam logic [95:0] DEF_SLV_MASK = {32'h1FC0_0000, 32'h1000_0000, 32'h1FC0_0000};

  typedef enum logic [1:0] {DP_NONE, DP_SLAVE, DP_DEFAULT} dp_kind_e;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/mfp_ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response, saturating error
// counter and capture of the most recent offending address.
module mfp_ahb_default_slave
  import mfp_ahb_matrix_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 accept_i,
  input  logic [ADDR_W-1:0]    haddr_i,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [ADDR_W-1:0]    err_addr_o,
  output logic [1:0]           state_o
);

  ds_state_e             state_q, state_d;
  logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // accept_i only rises while the bus is ready, i.e. never during ERR1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      DS_IDLE: if (accept_i) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = accept_i ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    if (accept_i) begin
      addr_d = haddr_i;
      if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count_o = cnt_q;
  assign err_addr_o  = addr_q;
  assign state_o     = state_q;

endmodule

// File: rtl/mfp_ahb_matrix.sv
// Single-master AHB-lite interconnect: priority address decode, registered data-phase
// select, and zero-latency response mux including a built-in default slave.
module mfp_ahb_matrix
  import mfp_ahb_matrix_pkg::*;
#(
  parameter int N_SLAVES  = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [ADDR_W-1:0]          HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  output logic [DATA_W-1:0]          HRDATA,
  output logic                       HREADY,
  output logic                       HRESP,
  output logic [N_SLAVES-1:0]        S_HSEL,
  input  logic [N_SLAVES*DATA_W-1:0] S_HRDATA,
  input  logic [N_SLAVES-1:0]        S_HREADYOUT,
  input  logic [N_SLAVES-1:0]        S_HRESP,
  output logic [ERR_CNT_W-1:0]       ERR_COUNT,
  output logic [ADDR_W-1:0]          ERR_ADDR
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  logic [N_SLAVES-1:0] hit;
  logic [N_SLAVES-1:0] sel_onehot;
  logic                any_hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                active;
  logic                accept_default;
  logic [1:0]          ds_state;
  dp_kind_e            dp_kind_q, dp_kind_d;
  logic [IDX_W-1:0]    dp_idx_q, dp_idx_d;

  // Write direction does not influence routing or responses.
  logic unused_hwrite;
  assign unused_hwrite = HWRITE;

  genvar g;
  generate
    for (g = 0; g < N_SLAVES; g++) begin : g_hit
      assign hit[g] = ((HADDR & SLV_MASK[g*ADDR_W +: ADDR_W]) == SLV_BASE[g*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Lowest index wins on overlapping windows.
  always_comb begin
    sel_onehot = '0;
    any_hit    = 1'b0;
    hit_idx    = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (hit[i] && !any_hit) begin
        sel_onehot[i] = 1'b1;
        any_hit       = 1'b1;
        hit_idx       = IDX_W'(i);
      end
    end
  end

  assign S_HSEL         = sel_onehot;
  assign active         = is_active(HTRANS);
  assign accept_default = HREADY && active && !any_hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_kind_q <= DP_NONE;
      dp_idx_q  <= '0;
    end else begin
      dp_kind_q <= dp_kind_d;
      dp_idx_q  <= dp_idx_d;
    end
  end

  always_comb begin
    dp_kind_d = dp_kind_q;
    dp_idx_d  = dp_idx_q;
    if (HREADY) begin
      if (!active) begin
        dp_kind_d = DP_NONE;
      end else if (any_hit) begin
        dp_kind_d = DP_SLAVE;
        dp_idx_d  = hit_idx;
      end else begin
        dp_kind_d = DP_DEFAULT;
      end
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    case (dp_kind_q)
      DP_SLAVE: begin
        for (int i = 0; i < N_SLAVES; i++) begin
          if (dp_idx_q == IDX_W'(i)) begin
            HREADY = S_HREADYOUT[i];
            HRESP  = S_HRESP[i];
            HRDATA = S_HRDATA[i*DATA_W +: DATA_W];
          end
        end
      end
      DP_DEFAULT: begin
        HREADY = (ds_state != DS_ERR1);
        HRESP  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  mfp_ahb_default_slave #(
    .ADDR_W   (ADDR_W),
    .ERR_CNT_W(ERR_CNT_W)
  ) u_default_slave (
    .clk_i      (HCLK),
    .rst_n_i    (HRESETn),
    .accept_i   (accept_default),
    .haddr_i    (HADDR),
    .err_count_o(ERR_COUNT),
    .err_addr_o (ERR_ADDR),
    .state_o    (ds_state)
  );

endmodule

// File: tb/tb_mfp_ahb_matrix.sv
// Randomised bench for mfp_ahb_matrix: a pipelined master/slave driver pushes expected
// data-phase responses; a negedge monitor pops and compares them.
module tb_mfp_ahb_matrix;
  import mfp_ahb_matrix_pkg::*;

  localparam int NS = 3;
  localparam logic [31:0] BASE_M  [3] = '{32'h1FC0_0000, 32'h0000_0000, 32'h1F80_0000};
  localparam logic [31:0] MASK_M  [3] = '{32'h1FC0_0000, 32'h1000_0000, 32'h1FC0_0000};
  localparam logic [31:0] BASE5_M [5] = '{32'h4000_0000, 32'h4000_0000, 32'h0, 32'h8000_0000, 32'hC000_0000};
  localparam logic [31:0] MASK5_M [5] = '{32'hF000_0000, 32'hC000_0000, 32'h0, 32'h8000_0000, 32'hC000_0000};

  logic        clk, rst_n;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready, hresp;
  logic [2:0]  s_hsel;
  logic [95:0] s_hrdata;
  logic [2:0]  s_hreadyout, s_hresp;
  logic [7:0]  err_count;
  logic [31:0] err_addr;

  logic [31:0]  hrdata5, err_addr5;
  logic         hready5, hresp5;
  logic [4:0]   s_hsel5;
  logic [7:0]   err_count5;
  logic [159:0] s_hrdata5;
  logic [4:0]   s_hreadyout5, s_hresp5;

  mfp_ahb_matrix dut (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .S_HSEL(s_hsel),
    .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
    .ERR_COUNT(err_count), .ERR_ADDR(err_addr)
  );

  mfp_ahb_matrix #(
    .N_SLAVES(5),
    .SLV_BASE({32'hC000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 32'h4000_0000}),
    .SLV_MASK({32'hC000_0000, 32'h8000_0000, 32'h0000_0000, 32'hC000_0000, 32'hF000_0000})
  ) dut5 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HTRANS(2'b00), .HWRITE(1'b0),
    .HRDATA(hrdata5), .HREADY(hready5), .HRESP(hresp5), .S_HSEL(s_hsel5),
    .S_HRDATA(s_hrdata5), .S_HREADYOUT(s_hreadyout5), .S_HRESP(s_hresp5),
    .ERR_COUNT(err_count5), .ERR_ADDR(err_addr5)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] data;
    logic        resp;
    int          waits;
    logic        wait_resp;
    logic [7:0]  ecnt;
    logic [31:0] eaddr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  bit   mon_en = 0;
  int   wait_seen = 0;

  // pending address phase
  logic [31:0] p_addr, p_data;
  logic [1:0]  p_trans;
  logic        p_write, p_err;
  int          p_waits;
  // data phase as seen by the reference model
  int          dp_tgt, dp_rem;
  logic [31:0] dp_data;
  logic        dp_err;
  logic [7:0]  m_ecnt;
  logic [31:0] m_eaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_act(input logic [1:0] tr);
    return (tr == 2'b10) || (tr == 2'b11);
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & MASK_M[i]) == BASE_M[i]) return i;
    return -1;
  endfunction

  function automatic int decode5(input logic [31:0] a);
    for (int i = 0; i < 5; i++) if ((a & MASK5_M[i]) == BASE5_M[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int t);
    return (t < 0) ? 32'd0 : (32'd1 << t);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic plan(input logic [31:0] a, input logic [1:0] tr, input int waits,
                      input logic err, input logic [31:0] d);
    p_addr  = a;
    p_trans = tr;
    p_write = 1'($urandom_range(0, 1));
    p_waits = err ? 1 : waits;
    p_err   = err;
    p_data  = d;
  endtask

  task automatic plan_random(input int mode);
    logic [31:0] a;
    logic [1:0]  tr;
    int          t, tries;
    tr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    if (mode == 0) begin
      t = $urandom_range(0, NS - 1);
      a = ($urandom & ~MASK_M[t]) | BASE_M[t];
      plan(a, tr, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);
    end else begin
      a = $urandom;
      tries = 0;
      while (decode(a) != -1 && tries < 100) begin
        a = $urandom;
        tries++;
      end
      if (decode(a) != -1) a = 32'h1000_0000;
      plan(a, (mode == 2) ? 2'b10 : tr, 0, 1'b0, $urandom);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NS; i++) begin
      s_hreadyout[i]      = 1'($urandom_range(0, 1));
      s_hresp[i]          = 1'($urandom_range(0, 1));
      s_hrdata[i*32 +: 32] = $urandom;
    end
    if (dp_tgt >= 0) begin
      s_hreadyout[dp_tgt]       = (dp_rem == 0);
      s_hresp[dp_tgt]           = dp_err && (dp_rem <= 1);
      s_hrdata[dp_tgt*32 +: 32] = (dp_rem == 0) ? dp_data : $urandom;
    end
    if (dp_rem == 0) begin
      haddr  = p_addr;
      htrans = p_trans;
      hwrite = p_write;
    end else begin
      haddr  = $urandom;
      htrans = 2'($urandom_range(0, 3));
      hwrite = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic open_dp();
    exp_t e;
    int   t;
    t = is_act(p_trans) ? decode(p_addr) : -2;
    if (t == -1) begin
      if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
      m_eaddr = p_addr;
      dp_rem  = 1;
      dp_err  = 1'b1;
      dp_data = 32'd0;
    end else if (t >= 0) begin
      dp_rem  = p_waits;
      dp_err  = p_err;
      dp_data = p_data;
    end else begin
      dp_rem  = 0;
      dp_err  = 1'b0;
      dp_data = 32'd0;
    end
    dp_tgt      = t;
    e.data      = dp_data;
    e.resp      = dp_err;
    e.waits     = dp_rem;
    e.wait_resp = dp_err;
    e.ecnt      = m_ecnt;
    e.eaddr     = m_eaddr;
    exp_q.push_back(e);
  endtask

  task automatic issue();
    bit done;
    done = 0;
    while (!done) begin
      drive_bus();
      @(posedge clk);
      #1;
      if (dp_rem == 0) begin
        open_dp();
        done = 1;
      end else begin
        dp_rem--;
      end
    end
  endtask

  task automatic model_reset();
    dp_tgt  = -2;
    dp_rem  = 0;
    dp_err  = 1'b0;
    dp_data = 32'd0;
    m_ecnt  = 8'd0;
    m_eaddr = 32'd0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("s_hsel", 32'(s_hsel), onehot(decode(haddr)));
        chk("s_hsel_n5", 32'(s_hsel5), onehot(decode5(haddr)));
        if (exp_q.size() > 0) begin
          if (!hready) begin
            wait_seen++;
            chk("wait_hresp", 32'(hresp), 32'(exp_q[0].wait_resp));
          end else begin
            e = exp_q.pop_front();
            chk("hrdata", hrdata, e.data);
            chk("hresp", 32'(hresp), 32'(e.resp));
            chk("wait_cycles", wait_seen, e.waits);
            chk("err_count", 32'(err_count), 32'(e.ecnt));
            chk("err_addr", err_addr, e.eaddr);
            wait_seen = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n       = 1'b0;
    haddr       = 32'hBFC0_0010;
    htrans      = HTRANS_IDLE;
    hwrite      = 1'b0;
    s_hrdata    = '0;
    s_hreadyout = '1;
    s_hresp     = '0;
    s_hrdata5    = '0;
    s_hreadyout5 = '1;
    s_hresp5     = '0;
    #2;
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_s_hsel", 32'(s_hsel), 32'b001);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;

    // directed opening sequence
    plan(32'hBFC0_0010, HTRANS_NONSEQ, 0, 1'b0, 32'hA5A5_0001); issue();
    plan(32'h8000_0100, HTRANS_NONSEQ, 3, 1'b0, 32'h1234_5678); issue();
    plan(32'h1000_0000, HTRANS_NONSEQ, 0, 1'b0, 32'h0);         issue();
    plan(32'h1000_0000, HTRANS_IDLE,   0, 1'b0, 32'h0);         issue();
    plan(32'h1000_0000, HTRANS_NONSEQ, 0, 1'b0, 32'h0);         issue();
    plan(32'h1000_0004, HTRANS_SEQ,    0, 1'b0, 32'h0);         issue();
    plan(32'h1000_0008, HTRANS_BUSY,   0, 1'b0, 32'h0);         issue();
    plan(32'hBF80_0040, HTRANS_NONSEQ, 1, 1'b1, 32'hDEAD_BEEF); issue();

    for (int n = 0; n < 400; n++) begin
      plan_random(($urandom_range(0, 9) < 6) ? 0 : 1);
      issue();
    end

    // back-to-back unmapped NONSEQ until the counter saturates
    for (int n = 0; n < 300; n++) begin
      plan_random(2);
      issue();
    end
    plan(32'h0, HTRANS_IDLE, 0, 1'b0, 32'h0); issue();
    @(negedge clk);
    chk("err_count_sat", 32'(err_count), 32'd255);

    // reset in the middle of ERR1
    plan(32'h1000_0000, HTRANS_NONSEQ, 0, 1'b0, 32'h0); issue();
    mon_en = 0;
    chk("err1_hready", 32'(hready), 32'd0);
    chk("err1_hresp", 32'(hresp), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hready", 32'(hready), 32'd1);
    chk("midrst_hresp", 32'(hresp), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_err_addr", err_addr, 32'd0);
    exp_q.delete();
    wait_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;
    for (int n = 0; n < 40; n++) begin
      plan_random(($urandom_range(0, 3) == 0) ? 1 : 0);
      issue();
    end

    plan(32'h0, HTRANS_IDLE, 0, 1'b0, 32'h0); issue();
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
